// File: rtl/sub_arb_pkg.sv
// sub_arb_pkg: shared FSM state encodings and default operand width for the subtract arbiter.
package sub_arb_pkg;
  localparam int WIDTH = 4;
  typedef enum logic [1:0] {IDLE, SUB, NEG, RESP} state_t;
endpackage

// File: rtl/sub_arbiter_if.sv
// sub_arbiter_if: two-requester subtract request bus plus result handshake.
interface sub_arbiter_if #(parameter int WIDTH = sub_arb_pkg::WIDTH);
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [WIDTH-1:0] req_a0, req_b0, req_a1, req_b1;
  logic rsp_valid;
  logic rsp_id;
  logic [WIDTH-1:0] rsp_mag;
  logic rsp_neg;
  logic rsp_ready;
  modport master (output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
                  input req_ready, rsp_valid, rsp_id, rsp_mag, rsp_neg);
  modport slave (input req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
                 output req_ready, rsp_valid, rsp_id, rsp_mag, rsp_neg);
endinterface

// File: rtl/sub_core.sv
// sub_core: WIDTH-bit ripple-borrow subtractor chained from full_sub cells.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

module sub_core #(parameter int WIDTH = 4) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic [WIDTH-1:0] d,
  output logic             bo
);
  logic [WIDTH:0] c;
  assign c[0] = bi;
  assign bo = c[WIDTH];
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_sub u_fs (.a(a[i]), .b(b[i]), .bi(c[i]), .d(d[i]), .bo(c[i+1]));
  end
endmodule

// File: rtl/sub_arbiter.sv
// sub_arbiter: round-robin arbiter feeding two requesters into one shared |a-b| subtract core.
module sub_arbiter import sub_arb_pkg::*; #(parameter int WIDTH = sub_arb_pkg::WIDTH) (
  input logic clk,
  input logic rst_n,
  sub_arbiter_if.slave bus
);
  state_t state;
  logic last_grant, gnt_id, core_bo;
  logic [WIDTH-1:0] a, b, core_a, core_b, core_d;
  always_comb begin
    gnt_id = &bus.req_valid ? ~last_grant : bus.req_valid[1];
    bus.req_ready = (state == IDLE && rst_n) ? {bus.req_valid[1] & gnt_id, bus.req_valid[0] & ~gnt_id} : 2'b00;
    core_a = state == NEG ? '0 : a;
    core_b = state == NEG ? bus.rsp_mag : b;
  end
  sub_core #(.WIDTH(WIDTH)) u_core (.a(core_a), .b(core_b), .bi(1'b0), .d(core_d), .bo(core_bo));
  // rsp_mag doubles as the diff register; NEG negates it in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
      a <= '0;
      b <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= 1'b0;
      bus.rsp_mag <= '0;
      bus.rsp_neg <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (|bus.req_ready) begin
          a <= gnt_id ? bus.req_a1 : bus.req_a0;
          b <= gnt_id ? bus.req_b1 : bus.req_b0;
          bus.rsp_id <= gnt_id;
          last_grant <= gnt_id;
          state <= SUB;
        end
        SUB: begin
          bus.rsp_mag <= core_d;
          bus.rsp_neg <= core_bo;
          state <= core_bo ? NEG : RESP;
        end
        NEG: begin
          bus.rsp_mag <= core_d;
          state <= RESP;
        end
        RESP: if (bus.rsp_valid && bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          state <= IDLE;
        end else begin
          bus.rsp_valid <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sub_arbiter.sv
// tb_sub_arbiter: scoreboard-driven bench for the round-robin subtract arbiter.
module tb_sub_arbiter;
  localparam int W = sub_arb_pkg::WIDTH;
  typedef struct {logic id; logic [W-1:0] mag; logic neg; int lat;} exp_t;
  logic clk = 1'b0;
  logic rst_n;
  exp_t sb[$];
  int vectors = 0;
  int errors = 0;
  always #5 clk = ~clk;
  sub_arbiter_if bus();
  sub_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.id = id;
    e.neg = a < b;
    e.mag = a < b ? b - a : a - b;
    e.lat = a < b ? 3 : 2;
    return e;
  endfunction

  task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 0;
    if (id) begin bus.req_a1 = a; bus.req_b1 = b; end else begin bus.req_a0 = a; bus.req_b0 = b; end
    bus.req_valid = id ? 2'b10 : 2'b01;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (bus.req_ready[id]) begin @(posedge clk); #1; ok = 1; end
    end
    bus.req_valid = 2'b00;
    vectors++;
    if (!ok) begin errors++; $display("FAIL grant_timeout: requester %0d got no grant, expected grant within 20 cycles", id); end
    sb.push_back(model(id, a, b));
  endtask

  task automatic get_rsp(output int lat, output logic id, output logic [W-1:0] mag, output logic neg);
    int n = 0;
    while (n < 10 && bus.rsp_valid !== 1'b1) begin @(posedge clk); #1; n++; end
    lat = n; id = bus.rsp_id; mag = bus.rsp_mag; neg = bus.rsp_neg;
  endtask

  task automatic ack();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    @(posedge clk); #1;
    vectors++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", bus.req_ready); end
    vectors++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.rsp_valid); end
    vectors++; if ({bus.rsp_id, bus.rsp_mag, bus.rsp_neg} !== '0) begin errors++; $display("FAIL reset_rsp: got id %b mag %0d neg %b expected all 0", bus.rsp_id, bus.rsp_mag, bus.rsp_neg); end
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic ids [2] = '{1'b0, 1'b1};
    logic [W-1:0] as [2] = '{W'(9), W'(3)};
    logic [W-1:0] bs [2] = '{W'(3), W'(9)};
    int lat; logic id, neg; logic [W-1:0] mag; exp_t e;
    for (int k = 0; k < 2; k++) begin
      issue(ids[k], as[k], bs[k]);
      get_rsp(lat, id, mag, neg);
      e = sb.pop_front();
      vectors++; if (lat != e.lat) begin errors++; $display("FAIL single%0d_latency: got %0d expected %0d", k, lat, e.lat); end
      vectors++; if (id !== e.id) begin errors++; $display("FAIL single%0d_id: got %b expected %b", k, id, e.id); end
      vectors++; if (mag !== e.mag) begin errors++; $display("FAIL single%0d_mag: got %0d expected %0d", k, mag, e.mag); end
      vectors++; if (neg !== e.neg) begin errors++; $display("FAIL single%0d_neg: got %b expected %b", k, neg, e.neg); end
      ack();
    end
  endtask

  task automatic test_boundary();
    logic [W-1:0] as [4] = '{W'(0), W'(5), W'(15), W'(0)};
    logic [W-1:0] bs [4] = '{W'(8), W'(5), W'(0), W'(15)};
    int lat; logic id, neg; logic [W-1:0] mag; exp_t e;
    for (int k = 0; k < 4; k++) begin
      issue(k[0], as[k], bs[k]);
      get_rsp(lat, id, mag, neg);
      e = sb.pop_front();
      vectors++; if (lat != e.lat) begin errors++; $display("FAIL bound%0d_latency: got %0d expected %0d", k, lat, e.lat); end
      vectors++; if ({id, mag, neg} !== {e.id, e.mag, e.neg}) begin errors++; $display("FAIL bound%0d_rsp: got id %b mag %0d neg %b expected id %b mag %0d neg %b", k, id, mag, neg, e.id, e.mag, e.neg); end
      ack();
    end
  endtask

  task automatic test_round_robin();
    int lat; logic id, neg; logic [W-1:0] mag; exp_t e;
    do_reset();
    bus.req_a0 = W'(7); bus.req_b0 = W'(2); bus.req_a1 = W'(2); bus.req_b1 = W'(7);
    for (int k = 0; k < 4; k++) sb.push_back(k[0] ? model(1'b1, W'(2), W'(7)) : model(1'b0, W'(7), W'(2)));
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      get_rsp(lat, id, mag, neg);
      e = sb.pop_front();
      vectors++; if ({id, mag, neg} !== {e.id, e.mag, e.neg}) begin errors++; $display("FAIL rr%0d: got id %b mag %0d neg %b expected id %b mag %0d neg %b", k, id, mag, neg, e.id, e.mag, e.neg); end
      ack();
    end
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat; logic id, neg; logic [W-1:0] mag; exp_t e;
    issue(1'b1, W'(12), W'(5));
    get_rsp(lat, id, mag, neg);
    e = sb.pop_front();
    vectors++; if ({id, mag, neg} !== {e.id, e.mag, e.neg}) begin errors++; $display("FAIL bp_rsp: got id %b mag %0d neg %b expected id %b mag %0d neg %b", id, mag, neg, e.id, e.mag, e.neg); end
    bus.req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      vectors++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_mag, bus.rsp_neg} !== {1'b1, e.id, e.mag, e.neg}) begin errors++; $display("FAIL bp_hold%0d: got valid %b id %b mag %0d neg %b expected valid 1 id %b mag %0d neg %b", k, bus.rsp_valid, bus.rsp_id, bus.rsp_mag, bus.rsp_neg, e.id, e.mag, e.neg); end
      vectors++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready%0d: got %b expected 00", k, bus.req_ready); end
    end
    bus.req_valid = 2'b00;
    ack();
    vectors++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got valid %b expected 0", bus.rsp_valid); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    issue(1'b0, W'(3), W'(9));
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    vectors++; if ({bus.rsp_valid, bus.rsp_mag, bus.req_ready} !== '0) begin errors++; $display("FAIL midrst_clear: got valid %b mag %0d ready %b expected all 0", bus.rsp_valid, bus.rsp_mag, bus.req_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    #1;
    vectors++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL midrst_grant: got %b expected 01", bus.req_ready); end
    bus.req_valid = 2'b00;
    for (int k = 0; k < 6; k++) begin @(posedge clk); #1; if (bus.rsp_valid) seen = 1; end
    vectors++; if (seen) begin errors++; $display("FAIL midrst_norsp: got a response, expected none"); end
  endtask

  initial begin
    bus.req_valid = 2'b00; bus.rsp_ready = 1'b0;
    bus.req_a0 = '0; bus.req_b0 = '0; bus.req_a1 = '0; bus.req_b1 = '0;
    test_reset();
    test_single();
    test_boundary();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
